// File: rtl/core_machine_timer.sv
// Machine timer for the core CSR space: prescaled 64-bit mtime, 64-bit mtimecmp,
// and a registered timer-interrupt level for the trap unit.
module core_machine_timer #(
    parameter logic [11:0] ADDRESS_BASE   = 12'h7C0,
    parameter int          PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrWriteEnable,
    input  logic        csrReadEnable,
    input  logic [11:0] csrWriteAddress,
    input  logic [11:0] csrReadAddress,
    input  logic [31:0] csrWriteData,
    output logic [31:0] csrReadData,
    output logic        requestOutput,
    input  logic        halt,
    output logic        isMachineTimerInterrupt
);
    localparam int NUM_REGS = 5;

    logic [NUM_REGS-1:0]       writeSel;
    logic [NUM_REGS-1:0]       readSel;
    logic [63:0]               mtimeReg;
    logic [63:0]               mtimecmpReg;
    logic                      enableReg;
    logic [PRESCALE_WIDTH-1:0] prescaleReg;
    logic [PRESCALE_WIDTH-1:0] prescaleCountReg;
    logic                      irqReg;
    logic                      countEnable;
    logic                      tick;
    logic                      mtimeWrite;
    logic [31:0]               ctrlWord;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gen_decode
            assign writeSel[gi] = csrWriteEnable && (csrWriteAddress == ADDRESS_BASE + 12'(gi));
            assign readSel[gi]  = csrReadEnable  && (csrReadAddress  == ADDRESS_BASE + 12'(gi));
        end
    endgenerate

    assign countEnable = enableReg && !halt;
    assign tick        = countEnable && (prescaleCountReg == prescaleReg);
    assign mtimeWrite  = writeSel[0] || writeSel[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            mtimeReg         <= '0;
            mtimecmpReg      <= '1;
            enableReg        <= 1'b0;
            prescaleReg      <= '0;
            prescaleCountReg <= '0;
            irqReg           <= 1'b0;
        end else begin
            // A software write to either mtime word wins over that cycle's tick.
            if (mtimeWrite) begin
                if (writeSel[0]) mtimeReg[31:0]  <= csrWriteData;
                if (writeSel[1]) mtimeReg[63:32] <= csrWriteData;
            end else if (tick) begin
                mtimeReg <= mtimeReg + 64'd1;
            end

            if (writeSel[2]) mtimecmpReg[31:0]  <= csrWriteData;
            if (writeSel[3]) mtimecmpReg[63:32] <= csrWriteData;

            if (writeSel[4]) begin
                enableReg   <= csrWriteData[0];
                prescaleReg <= csrWriteData[8 +: PRESCALE_WIDTH];
            end

            if (mtimeWrite || writeSel[4] || tick) begin
                prescaleCountReg <= '0;
            end else if (countEnable) begin
                prescaleCountReg <= prescaleCountReg + PRESCALE_WIDTH'(1);
            end

            irqReg <= (mtimeReg >= mtimecmpReg);
        end
    end

    always_comb begin
        ctrlWord                      = '0;
        ctrlWord[0]                   = enableReg;
        ctrlWord[8 +: PRESCALE_WIDTH] = prescaleReg;
    end

    always_comb begin
        csrReadData = ({32{readSel[0]}} & mtimeReg[31:0])
                    | ({32{readSel[1]}} & mtimeReg[63:32])
                    | ({32{readSel[2]}} & mtimecmpReg[31:0])
                    | ({32{readSel[3]}} & mtimecmpReg[63:32])
                    | ({32{readSel[4]}} & ctrlWord);
    end

    assign requestOutput           = |readSel;
    assign isMachineTimerInterrupt = irqReg;
endmodule

// File: tb/tb_core_machine_timer.sv
// Directed bench for core_machine_timer; read expectations go into a scoreboard
// queue and a negedge monitor checks them against the DUT.
module tb_core_machine_timer;
    localparam logic [11:0] BASE = 12'h7C0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csrWriteEnable = 1'b0;
    logic        csrReadEnable = 1'b0;
    logic [11:0] csrWriteAddress = '0;
    logic [11:0] csrReadAddress = '0;
    logic [31:0] csrWriteData = '0;
    logic [31:0] csrReadData;
    logic        requestOutput;
    logic        halt = 1'b0;
    logic        isMachineTimerInterrupt;

    int checks = 0;
    int failures = 0;

    string       nameQ[$];
    logic        expReqQ[$];
    logic [31:0] expDataQ[$];
    int          expIrqQ[$];

    logic [31:0] resetExp [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};

    core_machine_timer #(.ADDRESS_BASE(BASE), .PRESCALE_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .csrWriteEnable(csrWriteEnable),
        .csrReadEnable(csrReadEnable),
        .csrWriteAddress(csrWriteAddress),
        .csrReadAddress(csrReadAddress),
        .csrWriteData(csrWriteData),
        .csrReadData(csrReadData),
        .requestOutput(requestOutput),
        .halt(halt),
        .isMachineTimerInterrupt(isMachineTimerInterrupt)
    );

    always #5 clk = ~clk;

    // Monitor: every read strobe seen mid-cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (csrReadEnable) begin
            if (expDataQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: read at addr %h with no expectation", csrReadAddress);
            end else begin
                string       n;
                logic        eReq;
                logic [31:0] eData;
                int          eIrq;
                n = nameQ.pop_front();
                eReq = expReqQ.pop_front();
                eData = expDataQ.pop_front();
                eIrq = expIrqQ.pop_front();
                checks++;
                if (requestOutput !== eReq) begin
                    failures++;
                    $display("FAIL %s requestOutput: got %b expected %b", n, requestOutput, eReq);
                end
                checks++;
                if (csrReadData !== eData) begin
                    failures++;
                    $display("FAIL %s csrReadData: got %h expected %h", n, csrReadData, eData);
                end
                if (eIrq >= 0) begin
                    checks++;
                    if (isMachineTimerInterrupt !== eIrq[0]) begin
                        failures++;
                        $display("FAIL %s irq: got %b expected %b", n, isMachineTimerInterrupt, eIrq[0]);
                    end
                end
                $display("read %-20s addr=%h data=%h req=%b irq=%b", n, csrReadAddress, csrReadData,
                         requestOutput, isMachineTimerInterrupt);
            end
        end
    end

    // One clock cycle with an optional write and an optional read; expIrq < 0 skips the irq check.
    task automatic step(input logic we, input logic [2:0] wOff, input logic [31:0] wData,
                        input logic re, input logic [2:0] rOff, input logic [31:0] expData,
                        input int expIrq, input string name);
        csrWriteEnable  = we;
        csrWriteAddress = BASE + 12'(wOff);
        csrWriteData    = wData;
        csrReadEnable   = re;
        csrReadAddress  = BASE + 12'(rOff);
        if (re) begin
            nameQ.push_back(name);
            expReqQ.push_back(rOff < 3'd5);
            expDataQ.push_back(expData);
            expIrqQ.push_back(expIrq);
        end
        @(posedge clk);
        #1;
        csrWriteEnable = 1'b0;
        csrReadEnable  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        step(1'b1, off, data, 1'b0, 3'd0, 32'h0, -1, "");
    endtask

    task automatic rd(input string name, input logic [2:0] off, input logic [31:0] exp, input int irq);
        step(1'b0, 3'd0, 32'h0, 1'b1, off, exp, irq, name);
    endtask

    task automatic wrd(input string name, input logic [2:0] wOff, input logic [31:0] wData,
                       input logic [2:0] rOff, input logic [31:0] exp, input int irq);
        step(1'b1, wOff, wData, 1'b1, rOff, exp, irq, name);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) rd("reset_value", 3'(i), resetExp[i], 0);
        rd("unmapped_addr", 3'd5, 32'h0, 0);

        // Prescale 0: count every cycle, compare at 10.
        wr(3'd2, 32'd10);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'h1);
        for (int j = 1; j <= 14; j++) rd("ps0_count", 3'd0, 32'(j - 1), (j >= 12) ? 1 : 0);
        wrd("ps0_disable", 3'd4, 32'h0, 3'd0, 32'd14, 1);
        wrd("cmph_raise", 3'd3, 32'hFFFF_FFFF, 3'd0, 32'd15, 1);
        rd("irq_latency", 3'd3, 32'hFFFF_FFFF, 1);
        rd("irq_dropped", 3'd0, 32'd15, 0);

        // Prescale 3 with a 5-cycle halt.
        wr(3'd0, 32'h0);
        wr(3'd4, 32'hFFFF_0301);
        rd("ctrl_readback", 3'd4, 32'h301, 0);
        for (int j = 2; j <= 9; j++) rd("ps3_count", 3'd0, 32'((j - 1) / 4), 0);
        halt = 1'b1;
        for (int j = 10; j <= 14; j++) rd("ps3_halted", 3'd0, 32'd2, 0);
        halt = 1'b0;
        for (int j = 15; j <= 17; j++) rd("ps3_after_halt", 3'd0, 32'd2, 0);
        rd("ps3_delayed_tick", 3'd0, 32'd3, 0);

        // Write collisions: in a tick cycle, then mid-prescale.
        wr(3'd4, 32'h301);
        for (int j = 0; j < 3; j++) rd("coll_wait", 3'd0, 32'd3, 0);
        wrd("coll_tick_pre", 3'd0, 32'h55, 3'd0, 32'd3, 0);
        for (int j = 0; j < 4; j++) rd("coll_no_inc", 3'd0, 32'h55, 0);
        rd("coll_next_tick", 3'd0, 32'h56, 0);
        wrd("coll_mid_pre", 3'd0, 32'h10, 3'd0, 32'h56, 0);
        for (int j = 0; j < 4; j++) rd("coll_restart", 3'd0, 32'h10, 0);
        rd("coll_restart_tick", 3'd0, 32'h11, 0);

        // Carry from low word into high word.
        wr(3'd4, 32'h0);
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h1);
        wrd("carry_pre", 3'd4, 32'h0, 3'd0, 32'hFFFF_FFFF, 0);
        rd("carry_high", 3'd1, 32'h1, 0);
        rd("carry_low", 3'd0, 32'h0, 0);

        // Full 64-bit wrap.
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd4, 32'h1);
        wrd("wrap_pre", 3'd4, 32'h0, 3'd1, 32'hFFFF_FFFF, -1);
        rd("wrap_high", 3'd1, 32'h0, -1);
        rd("wrap_low", 3'd0, 32'h0, -1);

        // Reset mid-count with the interrupt high and a colliding write.
        wr(3'd2, 32'd5);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'h1);
        for (int j = 1; j <= 8; j++) rd("pre_rst_count", 3'd0, 32'(j - 1), (j >= 7) ? 1 : 0);
        rst = 1'b1;
        wr(3'd0, 32'h1234);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) rd("rst_midcount", 3'(i), resetExp[i], 0);
        rd("rst_no_count", 3'd0, 32'h0, 0);

        for (int i = 0; i < 20 && expDataQ.size() != 0; i++) @(posedge clk);
        if (expDataQ.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expDataQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
